// File: rtl/verichip_host_master_if.sv
// Host-side request/response handshake for the verichip bus initiator.
// The initiator (DUT) uses the slave modport; the host controller uses master.
interface verichip_host_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw_;
  logic [6:0]  req_addr;
  logic [1:0]  req_byte_en;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_rw_, req_addr, req_byte_en, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_rw_, req_addr, req_byte_en, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/verichip_host_master.sv
// Bus initiator for the verichip register interface: turns host requests into
// single-beat chip bus cycles and services chip interrupts on its own.
module verichip_host_master #(
  parameter int         CNT_W    = 8,
  parameter bit         IRQ_EN   = 1'b1,
  parameter logic [6:0] STA_ADDR = 7'h04
) (
  input  logic                  clk,
  input  logic                  rst_b,
  verichip_host_master_if.slave host,
  output logic                  chip_select,
  output logic [6:0]            address,
  output logic [1:0]            byte_en,
  output logic                  rw_,
  output logic [15:0]           data_in,
  input  logic [15:0]           data_out,
  input  logic                  interrupt_1,
  input  logic                  interrupt_2,
  output logic [15:0]           irq_status,
  output logic                  irq_done,
  output logic [CNT_W-1:0]      irq1_count,
  output logic [CNT_W-1:0]      irq2_count,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUS    = 3'd1,
    ST_RESP   = 3'd2,
    ST_IRQ_RD = 3'd3,
    ST_IRQ_WR = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             irq_pend_s, req_ready_s, ready_en_r;
  logic             cs_nxt_s, rw_nxt_s;
  logic [6:0]       addr_nxt_s;
  logic [1:0]       be_nxt_s;
  logic [15:0]      wd_nxt_s;
  logic             cs_r, rw_r;
  logic [6:0]       addr_r;
  logic [1:0]       be_r;
  logic [15:0]      wd_r;
  logic             rsp_valid_r, irq_done_r;
  logic [15:0]      rsp_rdata_r, irq_status_r;
  logic [CNT_W-1:0] irq1_cnt_r, irq2_cnt_r;

  assign irq_pend_s = IRQ_EN && (interrupt_1 || interrupt_2);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; interrupt service wins over a simultaneous request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (irq_pend_s) begin
          state_nxt_s = ST_IRQ_RD;
        end else if (host.req_valid && ready_en_r) begin
          state_nxt_s = ST_BUS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUS:    state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (host.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_IRQ_RD: state_nxt_s = ST_IRQ_WR;
      ST_IRQ_WR: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: bus values for the state being entered, so the registered
  // bus is valid for exactly the cycle that state lasts.
  always_comb begin
    req_ready_s = (state_r == ST_IDLE) && !irq_pend_s && ready_en_r;
    cs_nxt_s    = 1'b0;
    rw_nxt_s    = 1'b1;
    addr_nxt_s  = 7'h00;
    be_nxt_s    = 2'b00;
    wd_nxt_s    = 16'h0000;
    case (state_nxt_s)
      ST_BUS: begin
        cs_nxt_s   = 1'b1;
        addr_nxt_s = host.req_addr;
        rw_nxt_s   = host.req_rw_;
        if (host.req_rw_) begin
          be_nxt_s = 2'b00;
          wd_nxt_s = 16'h0000;
        end else begin
          be_nxt_s = host.req_byte_en;
          wd_nxt_s = host.req_wdata;
        end
      end
      ST_IRQ_RD: begin
        cs_nxt_s   = 1'b1;
        addr_nxt_s = STA_ADDR;
      end
      ST_IRQ_WR: begin
        // data_out here is the status being captured into irq_status this edge.
        cs_nxt_s   = 1'b1;
        rw_nxt_s   = 1'b0;
        addr_nxt_s = STA_ADDR;
        be_nxt_s   = 2'b10;
        wd_nxt_s   = {6'h00, data_out[9:8], 8'h00};
      end
      default: begin
        cs_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered chip bus; ready_en_r keeps req_ready low while in reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cs_r       <= 1'b0;
      rw_r       <= 1'b1;
      addr_r     <= 7'h00;
      be_r       <= 2'b00;
      wd_r       <= 16'h0000;
      ready_en_r <= 1'b0;
    end else begin
      cs_r       <= cs_nxt_s;
      rw_r       <= rw_nxt_s;
      addr_r     <= addr_nxt_s;
      be_r       <= be_nxt_s;
      wd_r       <= wd_nxt_s;
      ready_en_r <= 1'b1;
    end
  end

  // Response capture, interrupt status capture and saturating event counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= 16'h0000;
      irq_status_r <= 16'h0000;
      irq_done_r   <= 1'b0;
      irq1_cnt_r   <= {CNT_W{1'b0}};
      irq2_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      irq_done_r <= 1'b0;
      if (state_r == ST_BUS) begin
        rsp_valid_r <= 1'b1;
        rsp_rdata_r <= rw_r ? data_out : 16'h0000;
      end else if ((state_r == ST_RESP) && host.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
      if (state_r == ST_IRQ_RD) begin
        irq_status_r <= data_out;
      end
      if (state_r == ST_IRQ_WR) begin
        irq_done_r <= 1'b1;
        if (irq_status_r[8] && (irq1_cnt_r != {CNT_W{1'b1}})) begin
          irq1_cnt_r <= irq1_cnt_r + CNT_W'(1);
        end
        if (irq_status_r[9] && (irq2_cnt_r != {CNT_W{1'b1}})) begin
          irq2_cnt_r <= irq2_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign host.req_ready = req_ready_s;
  assign host.rsp_valid = rsp_valid_r;
  assign host.rsp_rdata = rsp_rdata_r;
  assign chip_select    = cs_r;
  assign address        = addr_r;
  assign byte_en        = be_r;
  assign rw_            = rw_r;
  assign data_in        = wd_r;
  assign irq_status     = irq_status_r;
  assign irq_done       = irq_done_r;
  assign irq1_count     = irq1_cnt_r;
  assign irq2_count     = irq2_cnt_r;
  assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_verichip_host_master.sv
// Self-checking bench: randomized host traffic and interrupts against a
// register-map reference model, with a behavioural chip on the bus.
module tb_verichip_host_master;
  localparam int         CNT_W = 2;
  localparam int         CMAX  = (1 << CNT_W) - 1;
  localparam logic [6:0] STA   = 7'h04;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  verichip_host_master_if host();
  logic             chip_select, rw_, irq_done, busy, interrupt_1, interrupt_2;
  logic [6:0]       address;
  logic [1:0]       byte_en;
  logic [15:0]      data_in, data_out, irq_status;
  logic [CNT_W-1:0] irq1_count, irq2_count;

  int total = 0;
  int bad   = 0;

  // chip environment
  logic [15:0] chip_mem [0:127];
  logic [1:0]  sta_pend, sta_clr, set_bits;
  logic [13:0] sta_low;
  // reference model
  logic [15:0] model_mem [0:127];
  int          exp_c1, exp_c2;

  always #5 clk = ~clk;

  verichip_host_master #(.CNT_W(CNT_W), .IRQ_EN(1'b1), .STA_ADDR(STA)) dut (
    .clk(clk), .rst_b(rst_b), .host(host),
    .chip_select(chip_select), .address(address), .byte_en(byte_en), .rw_(rw_),
    .data_in(data_in), .data_out(data_out),
    .interrupt_1(interrupt_1), .interrupt_2(interrupt_2),
    .irq_status(irq_status), .irq_done(irq_done),
    .irq1_count(irq1_count), .irq2_count(irq2_count), .busy(busy)
  );

  function automatic logic [15:0] init_val(input int a);
    logic [15:0] v;
    if (a == 0) v = 16'h0210;
    else        v = (16'(a) * 16'h0311) ^ 16'hA5C3;
    return v;
  endfunction

  // Chip: byte-lane register file, status bits 9:8 are set-priority write-1-to-clear.
  assign sta_clr = (chip_select && !rw_ && (address == STA) && byte_en[1]) ? data_in[9:8] : 2'b00;
  assign data_out = (address == STA) ? {sta_low[13:8], sta_pend, sta_low[7:0]} : chip_mem[address];
  assign interrupt_1 = sta_pend[0];
  assign interrupt_2 = sta_pend[1];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 128; i++) chip_mem[i] <= init_val(i);
      sta_pend <= 2'b00;
    end else begin
      if (chip_select && !rw_ && (address != STA)) begin
        if (byte_en[0]) chip_mem[address][7:0]  <= data_in[7:0];
        if (byte_en[1]) chip_mem[address][15:8] <= data_in[15:8];
      end
      sta_pend <= (sta_pend & ~sta_clr) | set_bits;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);
    exp_c1 = 0;
    exp_c2 = 0;
  endtask

  // Make the chip raise status bits; returns at the negedge where they are visible.
  task automatic raise_irq(input logic [1:0] bits, input logic [13:0] low);
    @(negedge clk);
    sta_low  = low;
    set_bits = bits;
    @(negedge clk);
    set_bits = 2'b00;
  endtask

  // Follows one service sequence from the negedge where the interrupt is visible.
  task automatic irq_service(input logic [1:0] bits, input logic [13:0] low);
    logic [15:0] st;
    st = {low[13:8], bits, low[7:0]};
    chk("irq_req_blocked", {30'h0, host.req_ready, busy}, 32'h0);
    @(negedge clk);
    chk("irq_rd_bus", {chip_select, rw_, address, byte_en}, {1'b1, 1'b1, STA, 2'b00});
    @(negedge clk);
    chk("irq_wr_bus", {chip_select, rw_, address, byte_en}, {1'b1, 1'b0, STA, 2'b10});
    chk("irq_wr_data", data_in, {6'h00, bits, 8'h00});
    chk("irq_status", irq_status, st);
    if (bits[0] && exp_c1 < CMAX) exp_c1++;
    if (bits[1] && exp_c2 < CMAX) exp_c2++;
    @(negedge clk);
    chk("irq_done", irq_done, 1);
    chk("irq1_count", irq1_count, exp_c1);
    chk("irq2_count", irq2_count, exp_c2);
    chk("irq_cleared", {interrupt_2, interrupt_1}, 2'b00);
    chk("irq_bus_idle", {chip_select, rw_, busy}, 3'b010);
  endtask

  task automatic irq_only(input logic [1:0] bits, input logic [13:0] low);
    raise_irq(bits, low);
    irq_service(bits, low);
    @(negedge clk);
    chk("irq_done_pulse", irq_done, 0);
  endtask

  task automatic do_req(input logic rw, input logic [6:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input int hold, input logic [1:0] irq_bits,
                        input logic [13:0] low, input bit rst_in_resp);
    logic [15:0] exp;
    int n;
    if (irq_bits != 2'b00) raise_irq(irq_bits, low);
    else @(negedge clk);
    host.req_valid   = 1'b1;
    host.req_rw_     = rw;
    host.req_addr    = a;
    host.req_byte_en = be;
    host.req_wdata   = wd;
    if (irq_bits != 2'b00) irq_service(irq_bits, low);
    n = 0;
    while (!host.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", host.req_ready, 1);
    @(negedge clk);
    host.req_valid = 1'b0;
    exp = rw ? model_mem[a] : 16'h0000;
    if (!rw) begin
      if (be[0]) model_mem[a][7:0]  = wd[7:0];
      if (be[1]) model_mem[a][15:8] = wd[15:8];
    end
    chk("bus_ctl", {chip_select, rw_, address}, {1'b1, rw, a});
    chk("bus_wr", {byte_en, data_in}, rw ? 18'h0 : {be, wd});
    @(negedge clk);
    chk("rsp_valid", host.rsp_valid, 1);
    chk("rsp_rdata", host.rsp_rdata, exp);
    chk("bus_idle", {chip_select, rw_, address, byte_en, data_in}, {1'b0, 1'b1, 7'h00, 2'b00, 16'h0000});
    if (rst_in_resp) begin
      #2 rst_b = 1'b0;
      #1 chk("rst_resp", {host.rsp_valid, host.rsp_rdata, busy, host.req_ready}, 32'h0);
      model_reset();
      @(negedge clk);
      rst_b = 1'b1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {host.rsp_valid, host.req_ready, host.rsp_rdata}, {1'b1, 1'b0, exp});
    end
    host.rsp_ready = 1'b1;
    @(negedge clk);
    host.rsp_ready = 1'b0;
    chk("rsp_done", {host.rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    logic [6:0]  ra;
    logic [13:0] rl;
    host.req_valid   = 1'b0;
    host.req_rw_     = 1'b1;
    host.req_addr    = 7'h00;
    host.req_byte_en = 2'b00;
    host.req_wdata   = 16'h0000;
    host.rsp_ready   = 1'b0;
    set_bits         = 2'b00;
    sta_low          = 14'h0000;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_bus", {chip_select, rw_, address, byte_en, data_in}, {1'b0, 1'b1, 7'h00, 2'b00, 16'h0000});
    chk("rst_host", {host.req_ready, host.rsp_valid, host.rsp_rdata}, 32'h0);
    chk("rst_irq", {irq_status, irq_done, irq1_count, irq2_count, busy}, 32'h0);
    rst_b = 1'b1;

    // directed register traffic
    do_req(1'b1, 7'h00, 2'b00, 16'h0000, 0, 2'b00, 14'h0, 1'b0);
    do_req(1'b0, 7'h10, 2'b11, 16'h0005, 1, 2'b00, 14'h0, 1'b0);
    do_req(1'b0, 7'h18, 2'b11, 16'h0008, 0, 2'b00, 14'h0, 1'b0);
    do_req(1'b1, 7'h18, 2'b00, 16'h0000, 5, 2'b00, 14'h0, 1'b0);
    do_req(1'b0, 7'h20, 2'b01, 16'hBEEF, 0, 2'b00, 14'h0, 1'b0);
    do_req(1'b0, 7'h21, 2'b10, 16'hCAFE, 0, 2'b00, 14'h0, 1'b0);
    do_req(1'b1, 7'h20, 2'b00, 16'h0000, 0, 2'b00, 14'h0, 1'b0);
    do_req(1'b1, 7'h21, 2'b00, 16'h0000, 2, 2'b00, 14'h0, 1'b0);

    // interrupt service, priority over a request, saturation
    irq_only(2'b01, 14'h0002);
    do_req(1'b1, 7'h18, 2'b00, 16'h0000, 0, 2'b01, 14'h1234, 1'b0);
    for (int i = 0; i < 5; i++) irq_only(2'b01, 14'(i));
    chk("irq1_saturated", irq1_count, 2'd3);
    irq_only(2'b10, 14'h3FFF);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      ra = 7'($urandom_range(0, 127));
      if (ra == STA) ra = 7'h05;
      rl = 14'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        do_req(1'($urandom), ra, 2'($urandom), 16'($urandom), $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, rl, 1'b0);
      end else begin
        irq_only(2'($urandom_range(1, 3)), rl);
      end
    end

    // reset during IRQ_WR, then during RESP
    raise_irq(2'b11, 14'h0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_b = 1'b0;
    #1 chk("rst_in_irq_bus", {chip_select, rw_, address, byte_en, data_in, busy}, {1'b0, 1'b1, 7'h00, 2'b00, 16'h0000, 1'b0});
    chk("rst_in_irq_cnt", {irq_status, irq1_count, irq2_count, irq_done}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    do_req(1'b1, 7'h30, 2'b00, 16'h0000, 0, 2'b00, 14'h0, 1'b0);
    do_req(1'b1, 7'h31, 2'b00, 16'h0000, 0, 2'b00, 14'h0, 1'b1);
    do_req(1'b0, 7'h31, 2'b11, 16'h5A5A, 0, 2'b00, 14'h0, 1'b0);
    do_req(1'b1, 7'h31, 2'b00, 16'h0000, 1, 2'b00, 14'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
